// File: rtl/bus_timer_responder_if.sv
// ---------------------------------------------------------------------------
// bus_timer_responder_if
// CPU data-bus bundle between the CPU-side requester and a memory-mapped
// responder.
//   addr  : byte address driven by the requester
//   we    : write enable, the write is committed on the responder's clock edge
//   wdata : write data
//   rdata : read data, returned combinationally by the responder
// Modports: master (CPU side) and slave (responder side).
// ---------------------------------------------------------------------------
interface bus_timer_responder_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/bus_timer_responder.sv
// ---------------------------------------------------------------------------
// bus_timer_responder
// Memory-mapped down-counting timer that answers on the CPU data bus inside
// a 32-byte window at BASE_ADDR. The CPU programs the prescale, reload and
// control registers. The block counts down, flags expiry in STATUS and raises
// irq. Reads are zero-latency, so a read presents the pre-edge register values.
// Ports:
//   clk  : system clock, all state changes on posedge
//   rst  : asynchronous active-low reset
//   bus  : slave side of the CPU data bus (addr/we/wdata in, rdata out)
//   irq  : STATUS.expired & CTRL.irq_en
// Register map (word offsets inside the window):
//   0x00 CTRL RW [0]en (reads 1 only while running) [1]auto_reload [2]irq_en
//   0x04 PRESCALE RW, 0x08 LOAD RW, 0x0C COUNT RO, 0x10 STATUS RW1C [0]expired
// ---------------------------------------------------------------------------
module bus_timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_F020,
    parameter int          CNT_W     = 32,
    parameter int          PRE_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_timer_responder_if.slave bus,
    output logic                 irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_LOAD     = 3'd2;
    localparam logic [2:0] OFF_COUNT    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic             ctrl_auto_r;
    logic             ctrl_irq_en_r;
    logic [PRE_W-1:0] prescale_r;
    logic [CNT_W-1:0] load_r;
    logic [CNT_W-1:0] count_r;
    logic [PRE_W-1:0] pre_cnt_r;
    logic             expired_r;

    logic             hit_s;
    logic [2:0]       offset_s;
    logic             wr_s;
    logic             wr_ctrl_s;
    logic             wr_status_s;
    logic             run_s;
    logic             stop_s;
    logic             tick_s;
    logic             expire_s;
    logic [31:0]      prescale_ext_s;
    logic [31:0]      load_ext_s;
    logic [31:0]      count_ext_s;

    assign hit_s       = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign offset_s    = bus.addr[4:2];
    assign wr_s        = hit_s & bus.we;
    assign wr_ctrl_s   = wr_s & (offset_s == OFF_CTRL);
    assign wr_status_s = wr_s & (offset_s == OFF_STATUS);
    assign run_s       = (state_r == ST_RUN);
    // A stop request wins over a tick in the same cycle, so COUNT and the
    // prescale counter freeze exactly where they were.
    assign stop_s      = run_s & wr_ctrl_s & ~bus.wdata[0];
    // The >= compare keeps a smaller PRESCALE written mid-run from overshooting.
    assign tick_s      = run_s & ~stop_s & (pre_cnt_r >= prescale_r);
    assign expire_s    = tick_s & (count_r == '0);
    assign irq         = expired_r & ctrl_irq_en_r;

    // Software-programmed configuration registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_auto_r   <= 1'b0;
            ctrl_irq_en_r <= 1'b0;
            prescale_r    <= '0;
            load_r        <= '0;
        end else begin
            if (wr_ctrl_s) begin
                ctrl_auto_r   <= bus.wdata[1];
                ctrl_irq_en_r <= bus.wdata[2];
            end else begin
                ctrl_auto_r   <= ctrl_auto_r;
                ctrl_irq_en_r <= ctrl_irq_en_r;
            end
            if (wr_s && (offset_s == OFF_PRESCALE)) begin
                prescale_r <= bus.wdata[PRE_W-1:0];
            end else begin
                prescale_r <= prescale_r;
            end
            if (wr_s && (offset_s == OFF_LOAD)) begin
                load_r <= bus.wdata[CNT_W-1:0];
            end else begin
                load_r <= load_r;
            end
        end
    end

    // Run-state machine with the prescaler and the down counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            count_r   <= '0;
            pre_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (wr_ctrl_s && bus.wdata[0]) begin
                        state_r   <= ST_RUN;
                        count_r   <= load_r;
                        pre_cnt_r <= '0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    if (stop_s) begin
                        state_r <= ST_IDLE;
                    end else if (tick_s) begin
                        pre_cnt_r <= '0;
                        if (count_r != '0) begin
                            count_r <= count_r - CNT_ONE;
                        end else if (ctrl_auto_r) begin
                            count_r <= load_r;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end else begin
                        pre_cnt_r <= pre_cnt_r + PRE_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    count_r   <= '0;
                    pre_cnt_r <= '0;
                end
            endcase
        end
    end

    // Sticky expiry flag; a same-cycle expiry beats a write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expired_r <= 1'b0;
        end else if (expire_s) begin
            expired_r <= 1'b1;
        end else if (wr_status_s && bus.wdata[0]) begin
            expired_r <= 1'b0;
        end else begin
            expired_r <= expired_r;
        end
    end

    // Zero-latency read mux with narrow fields zero-extended to 32 bits.
    always_comb begin
        prescale_ext_s                = 32'd0;
        prescale_ext_s[PRE_W-1:0]     = prescale_r;
        load_ext_s                    = 32'd0;
        load_ext_s[CNT_W-1:0]         = load_r;
        count_ext_s                   = 32'd0;
        count_ext_s[CNT_W-1:0]        = count_r;
        bus.rdata                     = 32'd0;
        if (hit_s) begin
            case (offset_s)
                OFF_CTRL:     bus.rdata = {29'd0, ctrl_irq_en_r, ctrl_auto_r, run_s};
                OFF_PRESCALE: bus.rdata = prescale_ext_s;
                OFF_LOAD:     bus.rdata = load_ext_s;
                OFF_COUNT:    bus.rdata = count_ext_s;
                OFF_STATUS:   bus.rdata = {31'd0, expired_r};
                default:      bus.rdata = 32'd0;
            endcase
        end else begin
            bus.rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_bus_timer_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_timer_responder
// Directed bench for the bus timer. A behavioural model computes the timer
// state from elapsed run cycles (ticks = cycles / (PRESCALE+1), count derived
// from ticks modulo the reload period). A negedge compare process checks
// rdata and irq against the model every cycle. Literal expectations at key
// points pin the model itself.
// ---------------------------------------------------------------------------
module tb_bus_timer_responder;

    localparam logic [31:0] BASE   = 32'hFFFF_F020;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PRE  = BASE + 32'h04;
    localparam logic [31:0] A_LOAD = BASE + 32'h08;
    localparam logic [31:0] A_CNT  = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;

    logic clk;
    logic rst;
    logic irq;
    int   n_cmp;
    int   n_fail;

    bus_timer_responder_if bus_if ();

    bus_timer_responder #(
        .BASE_ADDR (BASE),
        .CNT_W     (32),
        .PRE_W     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if),
        .irq (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit              m_run;
    longint unsigned m_cycles;
    longint unsigned seg_load;
    longint unsigned seg_pre;
    bit              seg_auto;
    bit              m_auto;
    bit              m_irq_en;
    bit              m_exp;
    longint unsigned m_pre;
    longint unsigned m_load;
    longint unsigned m_hold;
    longint unsigned cur_v;
    longint unsigned k_v;
    bit              exp_now;
    bit              b_hit;
    logic [2:0]      b_off;

    function automatic longint unsigned m_count();
        longint unsigned k;
        if (m_run) begin
            k = m_cycles / (seg_pre + 64'd1);
            if (seg_auto) return seg_load - (k % (seg_load + 64'd1));
            return seg_load - k;
        end
        return m_hold;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (a[31:5] == BASE[31:5]) begin
            case (a[4:2])
                3'd0:    v = {29'd0, m_irq_en, m_auto, m_run};
                3'd1:    v = 32'(m_pre);
                3'd2:    v = 32'(m_load);
                3'd3:    v = 32'(m_count());
                3'd4:    v = {31'd0, m_exp};
                default: v = 32'd0;
            endcase
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run = 1'b0; m_cycles = 0; seg_load = 0; seg_pre = 0; seg_auto = 1'b0;
            m_auto = 1'b0; m_irq_en = 1'b0; m_exp = 1'b0;
            m_pre = 0; m_load = 0; m_hold = 0;
        end else begin
            b_hit   = (bus_if.addr[31:5] == BASE[31:5]) && bus_if.we;
            b_off   = bus_if.addr[4:2];
            cur_v   = m_count();
            exp_now = 1'b0;
            if (m_run) begin
                if (b_hit && b_off == 3'd0 && !bus_if.wdata[0]) begin
                    m_run  = 1'b0;
                    m_hold = cur_v;
                end else begin
                    m_cycles = m_cycles + 64'd1;
                    if (m_cycles % (seg_pre + 64'd1) == 64'd0) begin
                        k_v = m_cycles / (seg_pre + 64'd1);
                        if (k_v % (seg_load + 64'd1) == 64'd0) begin
                            exp_now = 1'b1;
                            if (!seg_auto) begin
                                m_run  = 1'b0;
                                m_hold = 0;
                            end
                        end
                    end
                end
            end else if (b_hit && b_off == 3'd0 && bus_if.wdata[0]) begin
                m_run    = 1'b1;
                m_cycles = 0;
                seg_load = m_load;
                seg_pre  = m_pre;
                seg_auto = bus_if.wdata[1];
            end
            if (b_hit && b_off == 3'd0) begin
                m_auto   = bus_if.wdata[1];
                m_irq_en = bus_if.wdata[2];
            end
            if (b_hit && b_off == 3'd1) m_pre = {48'd0, bus_if.wdata[15:0]};
            if (b_hit && b_off == 3'd2) m_load = {32'd0, bus_if.wdata};
            if (exp_now) m_exp = 1'b1;
            else if (b_hit && b_off == 3'd4 && bus_if.wdata[0]) m_exp = 1'b0;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_rdata", bus_if.rdata, m_read(bus_if.addr));
        check("model_irq", {31'd0, irq}, {31'd0, m_exp & m_irq_en});
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_if.addr  = a;
        bus_if.we    = 1'b1;
        bus_if.wdata = d;
        step();
        bus_if.we    = 1'b0;
        bus_if.wdata = 32'd0;
        bus_if.addr  = A_CNT;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus_if.addr = a;
        #1;
        check(name, bus_if.rdata, exp);
        bus_if.addr = A_CNT;
    endtask

    task automatic irq_chk(input logic exp, input string name);
        check(name, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rst          = 1'b0;
        bus_if.addr  = A_CNT;
        bus_if.we    = 1'b0;
        bus_if.wdata = 32'd0;
        repeat (2) step();
        rd_chk(A_CTRL, 32'd0, "reset_ctrl");
        irq_chk(1'b0, "reset_irq");
        rst = 1'b1;
        step();

        // One-shot: expiry exactly (3+1)*(1+1)=8 cycles after the CTRL write.
        wr(A_PRE, 32'd1);
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'd1);
        rd_chk(A_CNT, 32'd3, "oneshot_count0");
        repeat (7) step();
        rd_chk(A_STAT, 32'd0, "oneshot_not_yet");
        step();
        rd_chk(A_STAT, 32'd1, "oneshot_expired");
        rd_chk(A_CTRL, 32'd0, "oneshot_ctrl");
        rd_chk(A_CNT, 32'd0, "oneshot_count");
        step();
        wr(A_STAT, 32'd1);
        rd_chk(A_STAT, 32'd0, "oneshot_cleared");

        // Auto-reload with irq: count 2,1,0,2,...
        wr(A_PRE, 32'd0);
        wr(A_LOAD, 32'd2);
        wr(A_CTRL, 32'd7);
        rd_chk(A_CNT, 32'd2, "auto_c2");
        step();
        rd_chk(A_CNT, 32'd1, "auto_c1");
        irq_chk(1'b0, "auto_irq_low");
        step();
        rd_chk(A_CNT, 32'd0, "auto_c0");
        step();
        irq_chk(1'b1, "auto_irq_high");
        rd_chk(A_CNT, 32'd2, "auto_reload");
        rd_chk(A_CTRL, 32'd7, "auto_ctrl");

        // W1C race: clear off-expiry, then clear on the expiry cycle.
        wr(A_STAT, 32'd1);
        irq_chk(1'b0, "w1c_plain_irq");
        rd_chk(A_STAT, 32'd0, "w1c_plain");
        step();
        wr(A_STAT, 32'd1);
        rd_chk(A_STAT, 32'd1, "w1c_race");
        irq_chk(1'b1, "w1c_race_irq");
        wr(A_STAT, 32'd1);
        irq_chk(1'b0, "w1c_later_irq");
        rd_chk(A_STAT, 32'd0, "w1c_later");

        // Asynchronous reset mid-run, checked before any clock edge.
        step();
        step();
        irq_chk(1'b1, "prereset_irq");
        rst = 1'b0;
        #1;
        irq_chk(1'b0, "async_irq");
        rd_chk(A_CNT, 32'd0, "async_count");
        rd_chk(A_CTRL, 32'd0, "async_ctrl");
        step();
        rd_chk(A_LOAD, 32'd0, "async_load");
        rd_chk(A_PRE, 32'd0, "async_pre");
        step();
        rst = 1'b1;
        step();

        // Pause/resume and bus decode.
        wr(A_PRE, 32'd1);
        wr(A_LOAD, 32'd5);
        wr(A_CTRL, 32'd1);
        repeat (5) step();
        rd_chk(A_CNT, 32'd3, "pause_before");
        wr(A_CTRL, 32'd0);
        repeat (4) step();
        rd_chk(A_CNT, 32'd3, "pause_hold");
        rd_chk(A_CTRL, 32'd0, "pause_ctrl");
        step();
        wr(A_CTRL, 32'd1);
        rd_chk(A_CNT, 32'd5, "resume_reload");
        rd_chk(A_CTRL, 32'd1, "resume_ctrl");
        wr(BASE + 32'h40, 32'd0);
        rd_chk(A_CTRL, 32'd1, "alias_ignored");
        rd_chk(BASE + 32'h40, 32'd0, "alias_read");
        step();
        rd_chk(BASE + 32'h14, 32'd0, "reserved_read");
        wr(A_CNT, 32'h0000_00AB);
        rd_chk(A_CNT, 32'd4, "count_wr_ignored");
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
